// File: rtl/dekatron_ctrl_pkg.sv
// Shared types and constants for the dekatron step scheduler.
package dekatron_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} sched_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int unsigned DEFAULT_PULSE_PERIOD = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; Last remembers the previous winner (1 = requester 1).
module rr_arbiter2 (
    input  logic       hsClk,
    input  logic       Rst,
    input  logic [1:0] Req,
    input  logic       Update,
    output logic [1:0] GrantNext
);

    logic Last;

    always_comb begin
        GrantNext = 2'b00;
        case (Req)
            2'b01:   GrantNext = 2'b01;
            2'b10:   GrantNext = 2'b10;
            2'b11:   GrantNext = Last ? 2'b01 : 2'b10;
            default: GrantNext = 2'b00;
        endcase
    end

    // Reset value favours requester 0 on the first contention.
    always_ff @(posedge hsClk) begin
        if (Rst) begin
            Last <= 1'b1;
        end else if (Update) begin
            Last <= GrantNext[1];
        end
    end

endmodule

// File: rtl/dekatron_step_scheduler.sv
// Shares one dekatron pulse sender between two requesters, issuing N spaced
// forward/reverse strobes per request and acking the owner when done.
module dekatron_step_scheduler #(
    parameter int unsigned PULSE_PERIOD = dekatron_ctrl_pkg::DEFAULT_PULSE_PERIOD,
    parameter int unsigned GAP          = 2,
    parameter int unsigned STEPS_W      = 4
) (
    input  logic                 hsClk,
    input  logic                 Rst,
    input  logic [1:0]           Req,
    input  logic [1:0]           ReqDir,
    input  logic [2*STEPS_W-1:0] ReqSteps,
    output logic [1:0]           Grant,
    output logic [1:0]           Ack,
    output logic                 Busy,
    output logic                 PulseF,
    output logic                 PulseR
);

    import dekatron_ctrl_pkg::*;

    // The GAP parameter shadows the state name, so alias the state.
    localparam sched_state_t StGap = dekatron_ctrl_pkg::GAP;

    localparam int unsigned CntSpan = (PULSE_PERIOD > GAP)
        ? ((PULSE_PERIOD > 2) ? PULSE_PERIOD : 2)
        : ((GAP > 2) ? GAP : 2);
    localparam int unsigned CntW = $clog2(CntSpan);
    localparam logic [CntW-1:0] WaitLoad = CntW'((PULSE_PERIOD >= 2) ? PULSE_PERIOD - 2 : 0);
    localparam logic [CntW-1:0] GapLoad  = CntW'((GAP >= 1) ? GAP - 1 : 0);

    sched_state_t       state;
    logic               dir;
    logic [STEPS_W-1:0] rem;
    logic [CntW-1:0]    waitCnt;

    logic [1:0]         grantNext;
    logic               accept;
    logic               selDir;
    logic [STEPS_W-1:0] selSteps;
    logic               stepEnd;
    logic               moreSteps;

    assign accept   = (state == IDLE) && (|Req);
    assign selDir   = grantNext[1] ? ReqDir[1] : ReqDir[0];
    assign selSteps = grantNext[1] ? ReqSteps[STEPS_W +: STEPS_W] : ReqSteps[0 +: STEPS_W];

    // stepEnd marks the last cycle of a step window; the next cycle is the
    // following strobe or the Ack.
    assign stepEnd = ((state == ISSUE) && (PULSE_PERIOD < 2) && (GAP == 0))
                  || ((state == WAIT) && (waitCnt == '0) && (GAP == 0))
                  || ((state == StGap) && (waitCnt == '0));
    // In ISSUE rem has not yet been decremented.
    assign moreSteps = (state == ISSUE) ? (rem > STEPS_W'(1)) : (rem != '0);

    rr_arbiter2 u_arb (
        .hsClk     (hsClk),
        .Rst       (Rst),
        .Req       (Req),
        .Update    (accept),
        .GrantNext (grantNext)
    );

    always_ff @(posedge hsClk) begin
        if (Rst) begin
            state   <= IDLE;
            dir     <= DIR_FWD;
            rem     <= '0;
            waitCnt <= '0;
            Grant   <= 2'b00;
            Ack     <= 2'b00;
            Busy    <= 1'b0;
            PulseF  <= 1'b0;
            PulseR  <= 1'b0;
        end else begin
            Ack    <= 2'b00;
            PulseF <= 1'b0;
            PulseR <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        Grant <= grantNext;
                        Busy  <= 1'b1;
                        dir   <= selDir;
                        rem   <= selSteps;
                        if (selSteps != '0) begin
                            state  <= ISSUE;
                            PulseF <= (selDir == DIR_FWD);
                            PulseR <= (selDir == DIR_REV);
                        end else begin
                            state <= DONE;
                            Ack   <= grantNext;
                        end
                    end
                end
                ISSUE: begin
                    rem <= rem - STEPS_W'(1);
                    if (PULSE_PERIOD >= 2) begin
                        state   <= WAIT;
                        waitCnt <= WaitLoad;
                    end else if (GAP != 0) begin
                        state   <= StGap;
                        waitCnt <= GapLoad;
                    end
                end
                WAIT: begin
                    if (waitCnt != '0) begin
                        waitCnt <= waitCnt - CntW'(1);
                    end else if (GAP != 0) begin
                        state   <= StGap;
                        waitCnt <= GapLoad;
                    end
                end
                StGap: begin
                    if (waitCnt != '0) begin
                        waitCnt <= waitCnt - CntW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Grant <= 2'b00;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (stepEnd) begin
                if (moreSteps) begin
                    state  <= ISSUE;
                    PulseF <= (dir == DIR_FWD);
                    PulseR <= (dir == DIR_REV);
                end else begin
                    state <= DONE;
                    Ack   <= Grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_dekatron_step_scheduler.sv
// Directed bench: default instance (P=8, G=2) and a G=0 instance share stimulus.
module tb_dekatron_step_scheduler;

    logic       hsClk = 1'b0;
    logic       Rst;
    logic [1:0] Req;
    logic [1:0] ReqDir;
    logic [7:0] ReqSteps;

    logic [1:0] GrantA, AckA, Grant0, Ack0;
    logic       BusyA, PulseFA, PulseRA, Busy0, PulseF0, PulseR0;
    logic [6:0] vecA, vec0;

    int  total = 0;
    int  bad = 0;
    bit  propOn = 1'b0;

    always #5 hsClk = ~hsClk;

    dekatron_step_scheduler #(.PULSE_PERIOD(8), .GAP(2), .STEPS_W(4)) dut (
        .hsClk    (hsClk),
        .Rst      (Rst),
        .Req      (Req),
        .ReqDir   (ReqDir),
        .ReqSteps (ReqSteps),
        .Grant    (GrantA),
        .Ack      (AckA),
        .Busy     (BusyA),
        .PulseF   (PulseFA),
        .PulseR   (PulseRA)
    );

    dekatron_step_scheduler #(.PULSE_PERIOD(8), .GAP(0), .STEPS_W(4)) dut0 (
        .hsClk    (hsClk),
        .Rst      (Rst),
        .Req      (Req),
        .ReqDir   (ReqDir),
        .ReqSteps (ReqSteps),
        .Grant    (Grant0),
        .Ack      (Ack0),
        .Busy     (Busy0),
        .PulseF   (PulseF0),
        .PulseR   (PulseR0)
    );

    assign vecA = {GrantA, AckA, BusyA, PulseFA, PulseRA};
    assign vec0 = {Grant0, Ack0, Busy0, PulseF0, PulseR0};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Observe cycles t+1 .. t+end+1 of one request accepted at edge t.
    // Vector layout: {Grant[1:0], Ack[1:0], Busy, PulseF, PulseR}.
    task automatic serve(input string tag, input int who, input bit d, input int n,
                         input int t, input bit useZero, input int abortAt);
        int         endK;
        logic [1:0] oh;
        bit         strobe;
        logic [7:0] exp;
        logic [7:0] got;
        endK = 1 + n * t;
        oh = (who == 1) ? 2'b10 : 2'b01;
        for (int k = 1; k <= endK + 1; k++) begin
            @(negedge hsClk);
            strobe = (k < endK) && (((k - 1) % t) == 0);
            exp = {1'b0, (k <= endK) ? oh : 2'b00, (k == endK) ? oh : 2'b00,
                   k <= endK, strobe & !d, strobe & d};
            got = useZero ? {1'b0, vec0} : {1'b0, vecA};
            check($sformatf("%s_k%0d", tag, k), got, exp);
            if (k == endK) Req[who] = 1'b0;
            if (k == abortAt) begin
                Rst = 1'b1;
                Req = 2'b00;
                return;
            end
        end
    endtask

    task automatic resetPulse(input string tag);
        Rst = 1'b1;
        @(negedge hsClk);
        Rst = 1'b0;
        check({tag, "_a"}, {1'b0, vecA}, 8'h00);
        check({tag, "_z"}, {1'b0, vec0}, 8'h00);
    endtask

    always @(negedge hsClk) begin
        if (propOn) begin
            check("excl_a", {7'b0, PulseFA & PulseRA}, 8'h00);
            check("excl_z", {7'b0, PulseF0 & PulseR0}, 8'h00);
            check("onehot_a", {7'b0, $countones(GrantA) <= 1}, 8'h01);
            check("onehot_z", {7'b0, $countones(Grant0) <= 1}, 8'h01);
        end
    end

    initial begin
        Rst = 1'b1;
        Req = 2'b00;
        ReqDir = 2'b00;
        ReqSteps = 8'h00;
        repeat (3) @(negedge hsClk);
        resetPulse("rst1");
        propOn = 1'b1;

        ReqDir = 2'b00; ReqSteps = {4'd0, 4'd3}; Req = 2'b01;
        serve("fwd3", 0, 1'b0, 3, 10, 1'b0, 0);

        ReqDir = 2'b10; ReqSteps = {4'd1, 4'd0}; Req = 2'b10;
        serve("rev1", 1, 1'b1, 1, 10, 1'b0, 0);

        ReqDir = 2'b00; ReqSteps = {4'd0, 4'd0}; Req = 2'b01;
        serve("zero", 0, 1'b0, 0, 10, 1'b0, 0);

        resetPulse("rst2");
        ReqDir = 2'b10; ReqSteps = {4'd2, 4'd2}; Req = 2'b11;
        serve("conA_r0", 0, 1'b0, 2, 10, 1'b0, 0);
        serve("conA_r1", 1, 1'b1, 2, 10, 1'b0, 0);

        // Leave Last = 0 so requester 1 wins the next contention.
        ReqSteps = {4'd2, 4'd0}; Req = 2'b01;
        serve("zero2", 0, 1'b0, 0, 10, 1'b0, 0);
        ReqSteps = {4'd2, 4'd2}; Req = 2'b11;
        serve("conB_r1", 1, 1'b1, 2, 10, 1'b0, 0);
        serve("conB_r0", 0, 1'b0, 2, 10, 1'b0, 0);

        ReqDir = 2'b00; ReqSteps = {4'd0, 4'd5}; Req = 2'b01;
        serve("abort", 0, 1'b0, 5, 10, 1'b0, 13);
        @(negedge hsClk);
        check("abort_rst", {1'b0, vecA}, 8'h00);
        Rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge hsClk);
            check($sformatf("abort_idle%0d", i), {1'b0, vecA}, 8'h00);
        end
        ReqSteps = {4'd0, 4'd3}; Req = 2'b01;
        serve("fresh", 0, 1'b0, 3, 10, 1'b0, 0);

        resetPulse("rst3");
        ReqDir = 2'b00; ReqSteps = {4'd0, 4'd4}; Req = 2'b01;
        serve("gap0", 0, 1'b0, 4, 8, 1'b1, 0);

        propOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
